// File: rtl/tl_ram_responder.sv
// TileLink-UL RAM responder: one outstanding request, registered D response one cycle after A fires.
// Define TL_RAM_RESPONDER_LOGICAL_EN to add LogicalData (opcode 3) read-modify-write support.
module tl_ram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          DEPTH_WORDS = 64
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [2:0]  auto_in_a_bits_size,
    input  logic [1:0]  auto_in_a_bits_source,
    input  logic [31:0] auto_in_a_bits_address,
    input  logic [3:0]  auto_in_a_bits_mask,
    input  logic [31:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [2:0]  auto_in_d_bits_size,
    output logic [1:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_denied,
    output logic [31:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt,
    output logic        debug_state
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int AW = IW + 2;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state, state_next;

    logic [31:0] mem [DEPTH_WORDS];

    logic          a_fire;
    logic [IW-1:0] idx;
    logic          in_window;
    logic          aligned;
    logic          op_ok;
    logic          is_data_op;
    logic          legal;
    logic          wr_en;
    logic [31:0]   rd_word;
    logic [31:0]   new_word;
    logic [31:0]   wr_word;
    logic [2:0]    rsp_opcode;
    logic          rsp_denied;
    logic          rsp_corrupt;
    logic [31:0]   rsp_data;

    // Handshake: A fires on a_valid && a_ready (IDLE only); D fires on d_valid && d_ready (RESP only).
    always_comb begin
        state_next      = state;
        auto_in_a_ready = 1'b0;
        auto_in_d_valid = 1'b0;
        case (state)
            IDLE: begin
                auto_in_a_ready = 1'b1;
                if (auto_in_a_valid) state_next = RESP;
            end
            RESP: begin
                auto_in_d_valid = 1'b1;
                if (auto_in_d_ready) state_next = IDLE;
            end
        endcase
    end

    assign a_fire      = auto_in_a_valid && auto_in_a_ready;
    assign debug_state = (state == RESP);
    assign idx         = auto_in_a_bits_address[AW-1:2];
    assign in_window   = (auto_in_a_bits_address[31:AW] == BASE_ADDR[31:AW]);
    assign rd_word     = mem[idx];

    always_comb begin
        aligned = 1'b0;
        case (auto_in_a_bits_size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~auto_in_a_bits_address[0];
            3'd2:    aligned = (auto_in_a_bits_address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        op_ok      = 1'b0;
        is_data_op = 1'b0;
        new_word   = auto_in_a_bits_data;
        case (auto_in_a_bits_opcode)
            3'd0, 3'd1: op_ok = 1'b1;
            3'd4: begin
                op_ok      = 1'b1;
                is_data_op = 1'b1;
            end
`ifdef TL_RAM_RESPONDER_LOGICAL_EN
            3'd3: begin
                is_data_op = 1'b1;
                op_ok      = ~auto_in_a_bits_param[2];
                case (auto_in_a_bits_param[1:0])
                    2'd0: new_word = rd_word ^ auto_in_a_bits_data;
                    2'd1: new_word = rd_word | auto_in_a_bits_data;
                    2'd2: new_word = rd_word & auto_in_a_bits_data;
                    2'd3: new_word = auto_in_a_bits_data;
                endcase
            end
`endif
            default: op_ok = 1'b0;
        endcase

        legal = in_window && (auto_in_a_bits_size <= 3'd2) && aligned &&
                !auto_in_a_bits_corrupt && op_ok;
        wr_en = legal && (auto_in_a_bits_opcode != 3'd4);

        for (int b = 0; b < 4; b++) begin
            wr_word[8*b +: 8] = auto_in_a_bits_mask[b] ? new_word[8*b +: 8] : rd_word[8*b +: 8];
        end

        // Data-returning ops answer AccessAckData even when denied, with corrupt flagged.
        rsp_opcode  = is_data_op ? 3'd1 : 3'd0;
        rsp_denied  = !legal;
        rsp_corrupt = !legal && is_data_op;
        rsp_data    = (legal && is_data_op) ? rd_word : 32'd0;
    end

`ifndef TL_RAM_RESPONDER_LOGICAL_EN
    logic unused_param;
    assign unused_param = ^auto_in_a_bits_param;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state                  <= IDLE;
            auto_in_d_bits_opcode  <= 3'd0;
            auto_in_d_bits_size    <= 3'd0;
            auto_in_d_bits_source  <= 2'd0;
            auto_in_d_bits_denied  <= 1'b0;
            auto_in_d_bits_data    <= 32'd0;
            auto_in_d_bits_corrupt <= 1'b0;
        end else begin
            state <= state_next;
            if (a_fire) begin
                auto_in_d_bits_opcode  <= rsp_opcode;
                auto_in_d_bits_size    <= auto_in_a_bits_size;
                auto_in_d_bits_source  <= auto_in_a_bits_source;
                auto_in_d_bits_denied  <= rsp_denied;
                auto_in_d_bits_data    <= rsp_data;
                auto_in_d_bits_corrupt <= rsp_corrupt;
            end
        end
    end

    // RAM is not reset; a request accepted while reset is low must not land.
    always_ff @(posedge clock) begin
        if (reset && a_fire && wr_en) mem[idx] <= wr_word;
    end

endmodule

// File: tb/tb_tl_ram_responder.sv
// Directed, table-driven bench for tl_ram_responder; expectations follow TL_RAM_RESPONDER_LOGICAL_EN.
module tb_tl_ram_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_ready, a_valid;
    logic [2:0]  a_opcode, a_param, a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address, a_data;
    logic [3:0]  a_mask;
    logic        a_corrupt;
    logic        d_ready, d_valid;
    logic [2:0]  d_opcode, d_size;
    logic [1:0]  d_source;
    logic        d_denied, d_corrupt;
    logic [31:0] d_data;
    logic        dbg_state;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clock = ~clock;

    tl_ram_responder dut (
        .clock(clock), .reset(reset),
        .auto_in_a_ready(a_ready), .auto_in_a_valid(a_valid),
        .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_param(a_param),
        .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_source),
        .auto_in_a_bits_address(a_address), .auto_in_a_bits_mask(a_mask),
        .auto_in_a_bits_data(a_data), .auto_in_a_bits_corrupt(a_corrupt),
        .auto_in_d_ready(d_ready), .auto_in_d_valid(d_valid),
        .auto_in_d_bits_opcode(d_opcode), .auto_in_d_bits_size(d_size),
        .auto_in_d_bits_source(d_source), .auto_in_d_bits_denied(d_denied),
        .auto_in_d_bits_data(d_data), .auto_in_d_bits_corrupt(d_corrupt),
        .debug_state(dbg_state)
    );

    typedef struct {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [1:0]  source;
        logic [31:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
        logic [2:0]  e_opcode;
        logic        e_denied;
        logic        e_corrupt;
        logic [31:0] e_data;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [31:0] op, input logic [31:0] prm,
                                input logic [31:0] sz, input logic [31:0] src,
                                input logic [31:0] addr, input logic [31:0] msk,
                                input logic [31:0] dat, input logic [31:0] cor,
                                input logic [31:0] eop, input logic [31:0] eden,
                                input logic [31:0] ecor, input logic [31:0] edat);
        vec_t v;
        v.opcode    = op[2:0];
        v.param     = prm[2:0];
        v.size      = sz[2:0];
        v.source    = src[1:0];
        v.address   = addr;
        v.mask      = msk[3:0];
        v.data      = dat;
        v.corrupt   = cor[0];
        v.e_opcode  = eop[2:0];
        v.e_denied  = eden[0];
        v.e_corrupt = ecor[0];
        v.e_data    = edat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_req(input vec_t v, input int stall, input string tag);
        check({tag, ".a_ready_before"}, 32'(a_ready), 32'd1);
        a_opcode  = v.opcode;
        a_param   = v.param;
        a_size    = v.size;
        a_source  = v.source;
        a_address = v.address;
        a_mask    = v.mask;
        a_data    = v.data;
        a_corrupt = v.corrupt;
        a_valid   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a_valid = 1'b0;
        for (int c = 0; c <= stall; c++) begin
            check({tag, ".d_valid"},   32'(d_valid),   32'd1);
            check({tag, ".a_ready"},   32'(a_ready),   32'd0);
            check({tag, ".state"},     32'(dbg_state), 32'd1);
            check({tag, ".d_opcode"},  32'(d_opcode),  32'(v.e_opcode));
            check({tag, ".d_size"},    32'(d_size),    32'(v.size));
            check({tag, ".d_source"},  32'(d_source),  32'(v.source));
            check({tag, ".d_denied"},  32'(d_denied),  32'(v.e_denied));
            check({tag, ".d_corrupt"}, 32'(d_corrupt), 32'(v.e_corrupt));
            check({tag, ".d_data"},    d_data,         v.e_data);
            if (c < stall) @(negedge clock);
        end
        d_ready = 1'b1;
        @(negedge clock);
        d_ready = 1'b0;
        check({tag, ".d_valid_after"}, 32'(d_valid), 32'd0);
        check({tag, ".a_ready_after"}, 32'(a_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".a_ready"},   32'(a_ready),   32'd1);
        check({tag, ".d_valid"},   32'(d_valid),   32'd0);
        check({tag, ".d_opcode"},  32'(d_opcode),  32'd0);
        check({tag, ".d_size"},    32'(d_size),    32'd0);
        check({tag, ".d_source"},  32'(d_source),  32'd0);
        check({tag, ".d_denied"},  32'(d_denied),  32'd0);
        check({tag, ".d_corrupt"}, 32'(d_corrupt), 32'd0);
        check({tag, ".d_data"},    d_data,         32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_w4;
        vec_t        get4;

        reset = 1'b0; a_valid = 1'b0; d_ready = 1'b0;
        a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd0; a_source = 2'd0;
        a_address = 32'd0; a_mask = 4'd0; a_data = 32'd0; a_corrupt = 1'b0;

        vecs[0]  = mk(0, 0, 2, 2, 'h10004, 'hF, 'hDEADBEEF, 0, 0, 0, 0, 0);
        vecs[1]  = mk(4, 0, 2, 2, 'h10004, 'hF, 0, 0, 1, 0, 0, 'hDEADBEEF);
        vecs[2]  = mk(1, 0, 2, 1, 'h10004, 'h5, 'h11223344, 0, 0, 0, 0, 0);
        vecs[3]  = mk(4, 0, 2, 1, 'h10004, 'h0, 0, 0, 1, 0, 0, 'hDE22BE44);
        vecs[4]  = mk(4, 0, 2, 0, 'h10100, 'hF, 0, 0, 1, 1, 1, 0);
        vecs[5]  = mk(4, 0, 2, 3, 'h10002, 'hF, 0, 0, 1, 1, 1, 0);
        vecs[6]  = mk(0, 0, 2, 0, 'h10100, 'hF, 'h12345678, 0, 0, 1, 0, 0);
        vecs[7]  = mk(4, 0, 3, 0, 'h10008, 'hF, 0, 0, 1, 1, 1, 0);
        vecs[8]  = mk(2, 0, 2, 0, 'h10004, 'hF, 0, 0, 0, 1, 0, 0);
        vecs[9]  = mk(5, 0, 2, 1, 'h10004, 'hF, 0, 0, 0, 1, 0, 0);
        vecs[10] = mk(7, 0, 2, 2, 'h10004, 'hF, 0, 0, 0, 1, 0, 0);
        vecs[11] = mk(4, 0, 2, 1, 'h10004, 'hF, 0, 1, 1, 1, 1, 0);
        vecs[12] = mk(0, 0, 2, 0, 'h10008, 'hF, 'hCAFEF00D, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 2, 0, 'h10008, 'hF, 'h00000055, 1, 0, 1, 0, 0);
        vecs[14] = mk(1, 0, 0, 2, 'h10009, 'h2, 'h0000AB00, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 0, 1, 3, 'h1000A, 'hC, 'h12340000, 0, 0, 0, 0, 0);
        vecs[16] = mk(4, 0, 1, 0, 'h1000B, 'hC, 0, 0, 1, 1, 1, 0);
        vecs[17] = mk(4, 0, 0, 2, 'h10009, 'h2, 0, 0, 1, 0, 0, 'h1234AB0D);
        vecs[18] = mk(0, 0, 2, 1, 'h100FC, 'hF, 'h0A0B0C0D, 0, 0, 0, 0, 0);
        vecs[19] = mk(4, 0, 2, 1, 'h100FC, 'hF, 0, 0, 1, 0, 0, 'h0A0B0C0D);
        vecs[20] = mk(4, 0, 2, 0, 'h0FFFC, 'hF, 0, 0, 1, 1, 1, 0);
        vecs[21] = mk(0, 0, 2, 2, 'h10004, 'hF, 'hDEADBEEF, 0, 0, 0, 0, 0);
`ifdef TL_RAM_RESPONDER_LOGICAL_EN
        vecs[22] = mk(3, 0, 2, 2, 'h10004, 'hF, 'hFFFF0000, 0, 1, 0, 0, 'hDEADBEEF);
        vecs[23] = mk(4, 0, 2, 2, 'h10004, 'hF, 0, 0, 1, 0, 0, 'h2152BEEF);
        vecs[24] = mk(3, 3, 2, 1, 'h10004, 'h3, 'h12345678, 0, 1, 0, 0, 'h2152BEEF);
        vecs[25] = mk(4, 0, 2, 1, 'h10004, 'hF, 0, 0, 1, 0, 0, 'h21525678);
        vecs[26] = mk(3, 5, 2, 0, 'h10004, 'hF, 0, 0, 1, 1, 1, 0);
        exp_w4 = 32'h21525678;
`else
        vecs[22] = mk(3, 0, 2, 2, 'h10004, 'hF, 'hFFFF0000, 0, 0, 1, 0, 0);
        vecs[23] = mk(4, 0, 2, 2, 'h10004, 'hF, 0, 0, 1, 0, 0, 'hDEADBEEF);
        vecs[24] = mk(3, 3, 2, 1, 'h10004, 'h3, 'h12345678, 0, 0, 1, 0, 0);
        vecs[25] = mk(4, 0, 2, 1, 'h10004, 'hF, 0, 0, 1, 0, 0, 'hDEADBEEF);
        vecs[26] = mk(3, 5, 2, 0, 'h10004, 'hF, 0, 0, 0, 1, 0, 0);
        exp_w4 = 32'hDEADBEEF;
`endif

        // Reset state, then one idle cycle after release.
        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        check("reset.state", 32'(dbg_state), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("post_reset");

        for (int i = 0; i < NV; i++) begin
            run_req(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Backpressure: five stalled cycles, then back-to-back acceptance.
        get4 = mk(4, 0, 2, 3, 'h10004, 'hF, 0, 0, 1, 0, 0, exp_w4);
        run_req(get4, 5, "stall");
        run_req(get4, 0, "after_stall");

        // Reset while a response is pending drops it; RAM keeps its contents.
        a_opcode = 3'd4; a_size = 3'd2; a_source = 2'd2; a_address = 32'h10004;
        a_mask = 4'hF; a_data = 32'd0; a_corrupt = 1'b0; a_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a_valid = 1'b0;
        check("mid_resp.d_valid", 32'(d_valid), 32'd1);
        check("mid_resp.d_data", d_data, exp_w4);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check_reset_outputs("mid_resp_reset");
        run_req(get4, 0, "retained");

        // A write offered during reset is accepted by the handshake but must not land.
        reset = 1'b0;
        a_opcode = 3'd0; a_size = 3'd2; a_source = 2'd1; a_address = 32'h10004;
        a_mask = 4'hF; a_data = 32'h0; a_corrupt = 1'b0; a_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a_valid = 1'b0;
        reset = 1'b1;
        check_reset_outputs("write_in_reset");
        run_req(get4, 0, "discarded");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/tl_ram_responder.md
TL_RAM_RESPONDER -- requirements
Module: tl_ram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0001_0000, base byte address of the RAM window (aligned to window size).
REQ-002 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit RAM words (power of 2); window size = 4*DEPTH_WORDS bytes.
REQ-003 SHALL have port: clock  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port: reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: auto_in_a_ready out 1; auto_in_a_valid in 1; auto_in_a_bits_opcode in 3; auto_in_a_bits_param in 3; auto_in_a_bits_size in 3; auto_in_a_bits_source in 2; auto_in_a_bits_address in 32; auto_in_a_bits_mask in 4; auto_in_a_bits_data in 32; auto_in_a_bits_corrupt in 1 (TileLink A channel, responder side).
REQ-006 SHALL have ports: auto_in_d_ready in 1; auto_in_d_valid out 1; auto_in_d_bits_opcode out 3; auto_in_d_bits_size out 3; auto_in_d_bits_source out 2; auto_in_d_bits_denied out 1; auto_in_d_bits_data out 32; auto_in_d_bits_corrupt out 1 (TileLink D channel).

Function
REQ-007 SHALL implement two states: IDLE (a_ready=1, d_valid=0) and RESP (a_ready=0, d_valid=1).
REQ-008 SHALL, in IDLE on a_valid&&a_ready, execute the request in that cycle and enter RESP next cycle with D fields registered; latency A-fire to d_valid = 1 cycle.
REQ-009 SHALL hold all D fields stable while d_valid=1 and d_ready=0.
REQ-010 SHALL, in RESP on d_ready=1, return to IDLE next cycle; max throughput one request per 2 cycles; one outstanding request.
REQ-011 SHALL echo a_source and a_size into d_source and d_size.
REQ-012 SHALL treat request legal iff address in [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS), size<=2, address aligned to 2^size, a_corrupt=0, opcode supported.
REQ-013 SHALL, for legal Get (opcode 4), return AccessAckData (1) with word at address[log2(4*DEPTH_WORDS)-1:2], denied=0, corrupt=0; mask ignored.
REQ-014 SHALL, for legal PutFullData (0) or PutPartialData (1), write bytes enabled by a_mask only, return AccessAck (0), data=0, denied=0.
REQ-015 SHALL, for illegal request, not modify RAM; respond AccessAckData with denied=1, corrupt=1, data=0 if opcode is 4 (or 3 when REQ-020 applies), else AccessAck with denied=1, corrupt=0.
REQ-016 SHALL treat unsupported opcodes (2, 5, 6, 7; 3 without macro) as illegal, responding AccessAck denied=1.
REQ-017 SHALL never assert a_ready and d_valid in the same cycle.

Reset
REQ-018 SHALL, while reset=0 at a clock edge, enter IDLE; next cycle outputs: a_ready=1, d_valid=0, d_opcode=0, d_size=0, d_source=0, d_denied=0, d_data=0, d_corrupt=0.
REQ-019 SHALL drop a pending response on reset mid-RESP; RAM contents not reset; a write accepted in the reset cycle is discarded.

Configuration
REQ-020 SHALL, when TL_RAM_RESPONDER_LOGICAL_EN is defined, support LogicalData (opcode 3): param 0 XOR, 1 OR, 2 AND, 3 SWAP; apply to mask-enabled bytes; return AccessAckData with pre-op word; param 4..7 illegal.
REQ-021 SHALL, without TL_RAM_RESPONDER_LOGICAL_EN, contain no logical-op datapath and deny opcode 3 per REQ-016.

Verification
REQ-022 SHALL cover: PutFull addr 0x10004 data 0xDEADBEEF mask 0xF source 2, then Get same addr -> AccessAck src 2, then AccessAckData data 0xDEADBEEF denied 0.
REQ-023 SHALL cover: PutPartial addr 0x10004 data 0x11223344 mask 0x5 after REQ-022 -> Get returns 0xDE22BE44.
REQ-024 SHALL cover: Get addr 0x10100 (out of window) and Get size 2 addr 0x10002 (misaligned) -> denied=1, corrupt=1, data 0.
REQ-025 SHALL cover: d_ready held 0 for 5 cycles after A fire -> d_valid and D fields stable, a_ready=0 throughout; next A accepted cycle after d_ready=1 fire returns to IDLE.
REQ-026 SHALL cover: reset=0 asserted during RESP -> d_valid=0, a_ready=1 next cycle; RAM word from REQ-022 retained.
REQ-027 SHALL cover: with macro, LogicalData XOR 0xFFFF0000 mask 0xF on word 0xDEADBEEF -> returns 0xDEADBEEF, Get then returns 0x2152BEEF; without macro -> AccessAck denied=1, word unchanged.
